jt6295_chaddr: RTL and testbench

Four-channel ADPCM address sequencer for JT6295. It sits directly downstream of the phrase-table controller, which supplies `start`/`stop` flags, phrase addresses and attenuation. It time-multiplexes the four voices into four slots per sample frame, fetches one ROM byte per active slot and delivers one ADPCM nibble per slot to the decoder. It also returns `busy` and the frame marker `zero` to the controller.

---
 rtl/jt6295_chaddr.sv | 124 ++++++++++++
 tb/tb_jt6295_chaddr.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/jt6295_chaddr.sv
// jt6295_chaddr: four-channel ADPCM address sequencer, one ROM byte fetch and one nibble per slot
module jt6295_chaddr (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cen4_i,
    input  logic        cen1_i,
    input  logic [3:0]  start_i,
    input  logic [3:0]  stop_i,
    input  logic [17:0] start_addr_i,
    input  logic [17:0] stop_addr_i,
    input  logic [3:0]  att_i,
    output logic [3:0]  busy_o,
    output logic        zero_o,
    output logic [17:0] rom_addr_o,
    output logic        rom_cs_o,
    input  logic [7:0]  rom_data_i,
    input  logic        rom_ok_i,
    output logic [3:0]  nib_o,
    output logic [1:0]  nib_ch_o,
    output logic [3:0]  nib_att_o,
    output logic        nib_valid_o,
    output logic        miss_o
);
    typedef enum logic {IDLE, REQ} state_t;
    state_t      state_q, state_d;
    logic [1:0]  slot_q, slot_d;
    logic [3:0]  start_q, busy_q, go;
    logic [18:0] addr_q [4];
    logic [17:0] end_q [4];
    logic [3:0]  catt_q [4];
    logic [17:0] rom_addr_q, rom_addr_d;
    logic [3:0]  nib_q, nib_d, nib_att_q, nib_att_d;
    logic [1:0]  nib_ch_q, nib_ch_d;
    logic        nib_valid_q, nib_valid_d, miss_q, miss_d;
    logic        fetch, accept, last;

    assign go          = start_i & ~start_q & ~busy_q & ~stop_i;
    assign busy_o      = busy_q;
    assign zero_o      = slot_q == 2'd3;
    assign rom_cs_o    = state_q == REQ;
    assign rom_addr_o  = rom_addr_q;
    assign nib_o       = nib_q;
    assign nib_ch_o    = nib_ch_q;
    assign nib_att_o   = nib_att_q;
    assign nib_valid_o = nib_valid_q;
    assign miss_o      = miss_q;

    // Slot advance and fetch/accept decode; the channel in REQ is always the current slot
    always_comb begin
        slot_d = cen4_i ? (cen1_i ? 2'd0 : slot_q + 2'd1) : slot_q;
        fetch  = cen4_i && busy_q[slot_d] && !stop_i[slot_d];
        accept = state_q == REQ && !cen4_i && rom_ok_i && !stop_i[slot_q];
        last   = addr_q[slot_q][18:1] == end_q[slot_q] && addr_q[slot_q][0];
    end

    // Fetch FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else state_q <= state_d;
    end

    // Fetch FSM next state: a new slot restarts the FSM, a stop on the fetching channel aborts it
    always_comb begin
        state_d = cen4_i ? (fetch ? REQ : IDLE) : (accept || stop_i[slot_q]) ? IDLE : state_q;
    end

    // Fetch FSM outputs: ROM address on slot entry, nibble on accept, sticky miss on an unfinished slot
    always_comb begin
        rom_addr_d  = fetch ? addr_q[slot_d][18:1] : rom_addr_q;
        nib_d       = accept ? (addr_q[slot_q][0] ? rom_data_i[3:0] : rom_data_i[7:4]) : nib_q;
        nib_ch_d    = accept ? slot_q : nib_ch_q;
        nib_att_d   = accept ? catt_q[slot_q] : nib_att_q;
        nib_valid_d = accept;
        miss_d      = miss_q || (state_q == REQ && cen4_i && !stop_i[slot_q]);
    end

    // Slot counter and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q      <= 2'd0;
            rom_addr_q  <= 18'd0;
            nib_q       <= 4'd0;
            nib_ch_q    <= 2'd0;
            nib_att_q   <= 4'd0;
            nib_valid_q <= 1'b0;
            miss_q      <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            rom_addr_q  <= rom_addr_d;
            nib_q       <= nib_d;
            nib_ch_q    <= nib_ch_d;
            nib_att_q   <= nib_att_d;
            nib_valid_q <= nib_valid_d;
            miss_q      <= miss_d;
        end
    end

    // Channel registers: stop clears busy, start edge loads the phrase, accept advances or ends it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            start_q <= 4'd0;
            busy_q  <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                addr_q[i] <= 19'd0;
                end_q[i]  <= 18'd0;
                catt_q[i] <= 4'd0;
            end
        end else begin
            start_q <= start_i;
            for (int i = 0; i < 4; i++) begin
                if (stop_i[i]) busy_q[i] <= 1'b0;
                else if (go[i]) begin
                    addr_q[i] <= {start_addr_i, 1'b0};
                    end_q[i]  <= stop_addr_i;
                    catt_q[i] <= att_i;
                    busy_q[i] <= 1'b1;
                end else if (accept && slot_q == 2'(i)) begin
                    if (last) busy_q[i] <= 1'b0;
                    else addr_q[i] <= addr_q[i] + 19'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_jt6295_chaddr.sv
// tb_jt6295_chaddr: directed bench with a nibble scoreboard and a latency-modelled ROM
module tb_jt6295_chaddr;
    logic        clk_i = 1'b0, rst_ni = 1'b0, cen4_i = 1'b0, cen1_i = 1'b0;
    logic [3:0]  start_i, stop_i, att_i, busy_o, nib_o, nib_att_o;
    logic [17:0] start_addr_i, stop_addr_i, rom_addr_o;
    logic [7:0]  rom_data_i = 8'h00;
    logic        rom_ok_i = 1'b0, rom_cs_o, zero_o, nib_valid_o, miss_o;
    logic [1:0]  nib_ch_o;
    int          tests = 0, fails = 0, cc = 0, age = 0;
    logic        hold = 1'b0, log_en = 1'b0;
    logic [9:0]  sb [$];
    logic [17:0] alog [$];
    logic [17:0] wrap_exp [4];

    jt6295_chaddr dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cen4_i(cen4_i), .cen1_i(cen1_i),
        .start_i(start_i), .stop_i(stop_i), .start_addr_i(start_addr_i),
        .stop_addr_i(stop_addr_i), .att_i(att_i), .busy_o(busy_o), .zero_o(zero_o),
        .rom_addr_o(rom_addr_o), .rom_cs_o(rom_cs_o), .rom_data_i(rom_data_i),
        .rom_ok_i(rom_ok_i), .nib_o(nib_o), .nib_ch_o(nib_ch_o), .nib_att_o(nib_att_o),
        .nib_valid_o(nib_valid_o), .miss_o(miss_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] rom_byte(input logic [17:0] a);
        if (a == 18'h00100) return 8'hA5;
        if (a == 18'h00101) return 8'h3C;
        return 8'(a * 18'd37 + 18'd11);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk_i);
            #1;
        end
    endtask

    task automatic to_phase(input int ph);
        step();
        while (cc % 16 != ph) step();
    endtask

    task automatic push_nib(input logic [1:0] ch, input logic [3:0] a, input logic [17:0] addr, input bit lo);
        logic [7:0] b;
        b = rom_byte(addr);
        sb.push_back({ch, a, lo ? b[3:0] : b[7:4]});
    endtask

    task automatic launch(input int ch, input logic [17:0] sa, input logic [17:0] ea, input logic [3:0] a);
        start_addr_i = sa;
        stop_addr_i  = ea;
        att_i        = a;
        start_i[ch]  = 1'b1;
        step();
        chk("busy_rise", 32'(busy_o[ch]), 1);
        start_i[ch]  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            step();
            k++;
        end
        chk({tag, "_drained"}, sb.size(), 0);
    endtask

    initial begin
        start_i = 4'd0; stop_i = 4'd0; att_i = 4'd0;
        start_addr_i = 18'd0; stop_addr_i = 18'd0;
        wrap_exp = '{18'h3FFFF, 18'h3FFFF, 18'h00000, 18'h00000};
        fork
            forever begin
                @(negedge clk_i);
                age = (cen4_i || !rom_cs_o) ? 0 : age + 1;
                if (log_en && rom_cs_o && age == 0) alog.push_back(rom_addr_o);
                rom_ok_i   = rom_cs_o && age >= 1 && !hold;
                rom_data_i = rom_ok_i ? rom_byte(rom_addr_o) : 8'h00;
                cc++;
                cen4_i = cc % 4 == 0;
                cen1_i = cc % 16 == 0;
            end
            forever begin
                @(negedge clk_i);
                if (rst_ni && nib_valid_o) begin
                    chk("strobe_expected", 32'(sb.size() != 0), 1);
                    if (sb.size() != 0) chk("nibble", {nib_ch_o, nib_att_o, nib_o}, sb.pop_front());
                end
            end
        join_none
        step(3);
        chk("rst_busy", busy_o, 0);
        chk("rst_cs", rom_cs_o, 0);
        chk("rst_valid", nib_valid_o, 0);
        chk("rst_nib", {nib_ch_o, nib_att_o, nib_o}, 0);
        chk("rst_miss", miss_o, 0);
        chk("rst_zero", zero_o, 0);
        rst_ni = 1'b1;
        to_phase(1);
        for (int k = 0; k < 32; k++) begin
            chk("zero", zero_o, 32'((cc % 16) inside {13, 14, 15, 0}));
            chk("idle_cs", rom_cs_o, 0);
            step();
        end
        chk("idle_busy", busy_o, 0);
        sb.push_back({2'd2, 4'd5, 4'hA});
        sb.push_back({2'd2, 4'd5, 4'h5});
        sb.push_back({2'd2, 4'd5, 4'h3});
        sb.push_back({2'd2, 4'd5, 4'hC});
        to_phase(14);
        launch(2, 18'h00100, 18'h00101, 4'd5);
        drain("ch2");
        step();
        chk("ch2_busy_fall", busy_o, 0);
        chk("ch2_no_miss", miss_o, 0);
        push_nib(2'd0, 4'd3, 18'h00200, 1'b0);
        push_nib(2'd3, 4'hC, 18'h00300, 1'b0);
        push_nib(2'd0, 4'd3, 18'h00200, 1'b1);
        push_nib(2'd3, 4'hC, 18'h00300, 1'b1);
        to_phase(13);
        launch(3, 18'h00300, 18'h00300, 4'hC);
        launch(0, 18'h00200, 18'h00200, 4'd3);
        drain("ch03");
        step();
        chk("ch03_busy_fall", busy_o, 0);
        push_nib(2'd1, 4'd9, 18'h00400, 1'b0);
        push_nib(2'd1, 4'd9, 18'h00400, 1'b1);
        to_phase(14);
        launch(1, 18'h00400, 18'h0040F, 4'd9);
        drain("ch1");
        to_phase(5);
        chk("ch1_req_cs", rom_cs_o, 1);
        chk("ch1_req_addr", rom_addr_o, 18'h00401);
        stop_i[1] = 1'b1;
        step();
        chk("stop_busy", 32'(busy_o[1]), 0);
        chk("stop_cs", rom_cs_o, 0);
        start_i[1] = 1'b1;
        step(2);
        chk("stop_blocks_start", 32'(busy_o[1]), 0);
        step(40);
        stop_i[1] = 1'b0;
        step(20);
        chk("held_start_no_edge", 32'(busy_o[1]), 0);
        start_i[1] = 1'b0;
        chk("stop_no_miss", miss_o, 0);
        alog.delete();
        log_en = 1'b1;
        push_nib(2'd1, 4'd2, 18'h3FFFF, 1'b0);
        push_nib(2'd1, 4'd2, 18'h3FFFF, 1'b1);
        push_nib(2'd1, 4'd2, 18'h00000, 1'b0);
        push_nib(2'd1, 4'd2, 18'h00000, 1'b1);
        to_phase(14);
        launch(1, 18'h3FFFF, 18'h00000, 4'd2);
        drain("wrap");
        step();
        log_en = 1'b0;
        chk("wrap_busy_fall", busy_o, 0);
        chk("wrap_fetches", alog.size(), 4);
        for (int k = 0; k < 4; k++) chk("wrap_addr", k < alog.size() ? alog[k] : 18'hx, wrap_exp[k]);
        alog.delete();
        log_en = 1'b1;
        hold = 1'b1;
        push_nib(2'd0, 4'd7, 18'h00500, 1'b0);
        push_nib(2'd0, 4'd7, 18'h00500, 1'b1);
        to_phase(14);
        launch(0, 18'h00500, 18'h00500, 4'd7);
        to_phase(5);
        chk("miss_set", miss_o, 1);
        chk("miss_no_nibble", sb.size(), 2);
        hold = 1'b0;
        drain("miss");
        step();
        log_en = 1'b0;
        chk("miss_sticky", miss_o, 1);
        chk("miss_fetches", alog.size(), 3);
        for (int k = 0; k < 3; k++) chk("miss_addr", k < alog.size() ? alog[k] : 18'hx, 18'h00500);
        hold = 1'b1;
        to_phase(14);
        launch(2, 18'h00100, 18'h00101, 4'd5);
        for (int k = 0; k < 40 && !rom_cs_o; k++) step();
        chk("rst_mid_req", rom_cs_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("arst_cs", rom_cs_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_miss", miss_o, 0);
        chk("arst_valid", nib_valid_o, 0);
        chk("arst_zero", zero_o, 0);
        chk("arst_addr", rom_addr_o, 0);
        step(4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
